mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Consumer of the execute stage's outputs (icode, ifun, valE, valA, dstE, Cnd) plus valP/dstM from decode.
- Performs the Y86 data-memory access over a req/gnt/rvalid bus and presents the writeback bundle (valE, valM, dstE, dstM, stat) to the writeback stage with a valid/ready handshake.
- Handles one instruction at a time using a small FSM with back-pressure on both sides.

Parameters:
- DW, 32, data/address width (matches `WORD).
- TIMEOUT, 255, maximum cycles spent waiting in REQ or RD_WAIT before an ADR error is flagged; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  stage can accept a bundle.
- icode_i  in  8  instruction code (`BYTE).
- ifun_i  in  8  function code.
- valE_i  in  DW  ALU result / effective address.
- valA_i  in  DW  store data, or pop address.
- valP_i  in  DW  return address, stored by CALL.
- dstE_i  in  8  register destination for valE.
- dstM_i  in  8  register destination for valM.
- cnd_i  in  1  condition flag from execute.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  DW  bus address.
- mem_wdata  out  DW  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DW  read data.
- out_valid  out  1  writeback bundle valid.
- out_ready  in  1  writeback accepts the bundle.
- valE_o  out  DW  registered valE.
- valM_o  out  DW  loaded data (0 if no load).
- dstE_o  out  8  registered dstE; forced to 8'hF (none) for CMOVXX when cnd_i = 0.
- dstM_o  out  8  registered dstM.
- stat_o  out  3  1 = AOK, 3 = ADR, 4 = INS.

Behaviour:
- Reset (async, rst = 0):
  - state = IDLE.
  - All outputs 0, except dstE_o = dstM_o = 8'hF and stat_o = 1.
- in_ready = (state == IDLE). Capture happens when in_valid & in_ready. All inputs are registered at capture; later input changes are ignored.
- Access type decode at capture:
  - Read, addr = valE: MRMOVL (5).
  - Read, addr = valA: POPL (B), RET (9).
  - Write, addr = valE, data = valA: RMMOVL (4), PUSHL (A).
  - Write, addr = valE, data = valP: CALL (8).
  - No access: icodes 0,1,2,3,6,7.
  - Any icode > B: stat = INS, no access.
- FSM states: IDLE, REQ, RD_WAIT, DONE.
  - IDLE → REQ: on capture of an access instruction.
  - IDLE → DONE: on capture of a non-access instruction. out_valid rises the next cycle (1-cycle latency).
  - REQ: mem_req = 1 with mem_we, mem_addr and mem_wdata held stable until mem_gnt.
    - Write with gnt → DONE.
    - Read with gnt → RD_WAIT.
  - mem_req drops the cycle after gnt.
  - RD_WAIT: on mem_rvalid, valM_o ← mem_rdata, go to DONE. mem_rvalid is never expected in the same cycle as gnt; if it occurs there, it is ignored.
  - DONE: out_valid = 1 and the bundle is held stable until out_ready.
    - out_valid & out_ready → IDLE.
    - in_ready rises the cycle after the handshake (no same-cycle pass-through).
- Minimum latency:
  - Write with immediate gnt: 2 cycles from capture to out_valid.
  - Read with gnt then rvalid on the next cycle: 3 cycles.
- Timeout: a counter runs in REQ and RD_WAIT and clears on state entry. If it reaches TIMEOUT:
  - stat = ADR, valM = 0, go to DONE.
  - mem_req drops.
  - A late rvalid is ignored.
- DONE with out_ready low: hold indefinitely; no new capture.
- Reset mid-transaction: return to IDLE immediately and drop mem_req. The outstanding read is abandoned.
- Once captured, stat ≠ AOK is never cleared by later events.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - At capture, an access whose address[1:0] ≠ 0 skips REQ and goes straight to DONE with stat = ADR.
  - No bus request is issued; valM = 0.
- Undefined: addresses are passed to the bus unchanged and no alignment check is made.

Test Plan:
- Reset with rst = 0 during REQ → mem_req = 0 at once; after release, in_ready = 1, stat_o = 1, dstE_o = 8'hF.
- OPL: valE = 32'h15, dstE = 2 → out_valid 1 cycle after capture, valE_o = 32'h15, valM_o = 0, no mem_req.
- RMMOVL: valE = 32'h100, valA = 32'hDEAD, gnt held off 3 cycles → mem_req high 4 cycles with addr/data stable; mem_we = 1; out_valid after gnt.
- POPL: valA = 32'h1FC, rdata = 32'h42 with rvalid 2 cycles after gnt → mem_addr = 32'h1FC, mem_we = 0, valM_o = 32'h42, dstM_o passed through.
- MRMOVL, no gnt for TIMEOUT = 4 cycles → stat_o = 3, valM_o = 0, out_valid; out_ready held low 5 cycles keeps the bundle stable and in_ready = 0.
- With MEM_ALIGN_CHECK_EN, PUSHL with valE = 32'h102 → no mem_req, stat_o = 3; without the macro, mem_addr = 32'h102 and stat_o = 1.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : Y86 memory stage
//
// Takes one execute bundle at a time, performs the data-memory access it needs
// over a req/gnt/rvalid bus, and presents the writeback bundle under a
// valid/ready handshake. Back-pressure is applied upstream (in_ready) while a
// bundle is in flight, and is honoured downstream (out_ready).
//
// Parameters
//   DW       data / address width
//   TIMEOUT  cycles allowed in REQ or RD_WAIT before an ADR error (0 = never)
//
// Ports
//   clk, rst                    clock (rising edge), async active-low reset
//   in_valid / in_ready         execute-side handshake
//   icode_i, ifun_i             instruction and function codes
//   valE_i, valA_i, valP_i      ALU result/address, store data/pop addr, ret addr
//   dstE_i, dstM_i, cnd_i       register destinations, condition flag
//   mem_req/we/addr/wdata       bus request side (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata  bus response side
//   out_valid / out_ready       writeback-side handshake
//   valE_o, valM_o, dstE_o, dstM_o, stat_o   writeback bundle
//
// Optional build macro
//   MEM_ALIGN_CHECK_EN : a misaligned access address (addr[1:0] != 0) is
//                        rejected at capture with stat = ADR and no bus cycle.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    icode_i,
    input  logic [7:0]    ifun_i,
    input  logic [DW-1:0] valE_i,
    input  logic [DW-1:0] valA_i,
    input  logic [DW-1:0] valP_i,
    input  logic [7:0]    dstE_i,
    input  logic [7:0]    dstM_i,
    input  logic          cnd_i,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] valE_o,
    output logic [DW-1:0] valM_o,
    output logic [7:0]    dstE_o,
    output logic [7:0]    dstM_o,
    output logic [2:0]    stat_o
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [7:0] REG_NONE = 8'hF;
    localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD_WAIT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;

    logic          capture;
    logic          acc_rd, acc_wr, addr_from_a, data_from_p, bad_ins, misalign;
    logic [DW-1:0] cap_addr, cap_wdata;
    logic          tmo_hit, rd_done, timed_out;

    // Function code does not affect the memory access.
    logic          unused_ifun;
    assign unused_ifun = ^ifun_i;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mem_req   = (state == REQ);
    assign capture   = in_valid & in_ready;

    // Access-type decode of the incoming bundle; only used at capture.
    always_comb begin
        acc_rd      = 1'b0;
        acc_wr      = 1'b0;
        addr_from_a = 1'b0;
        data_from_p = 1'b0;
        bad_ins     = 1'b0;
        case (icode_i)
            8'h5:       acc_rd = 1'b1;
            8'h9, 8'hB: begin
                acc_rd      = 1'b1;
                addr_from_a = 1'b1;
            end
            8'h4, 8'hA: acc_wr = 1'b1;
            8'h8:       begin
                acc_wr      = 1'b1;
                data_from_p = 1'b1;
            end
            default:    bad_ins = (icode_i > 8'hB);
        endcase
        cap_addr  = addr_from_a ? valA_i : valE_i;
        cap_wdata = data_from_p ? valP_i : valA_i;
`ifdef MEM_ALIGN_CHECK_EN
        misalign  = (acc_rd | acc_wr) && (cap_addr[1:0] != 2'b00);
`else
        misalign  = 1'b0;
`endif
    end

    // Counter holds the number of cycles already spent in the current wait state.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT - 1));

    // Next-state logic; a bus response in the last allowed cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        rd_done   = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    if (bad_ins || misalign || !(acc_rd || acc_wr))
                        state_nxt = DONE;
                    else
                        state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt = mem_we ? DONE : RD_WAIT;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    timed_out = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                    rd_done   = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                    timed_out = 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                tmo_cnt <= '0;
            else if (state == REQ || state == RD_WAIT)
                tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    // Bundle and bus registers. An error status set at capture or by timeout is
    // never overwritten until the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valE_o    <= '0;
            valM_o    <= '0;
            dstE_o    <= REG_NONE;
            dstM_o    <= REG_NONE;
            stat_o    <= STAT_AOK;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (capture) begin
                valE_o    <= valE_i;
                valM_o    <= '0;
                dstE_o    <= (icode_i == 8'h2 && !cnd_i) ? REG_NONE : dstE_i;
                dstM_o    <= dstM_i;
                stat_o    <= bad_ins ? STAT_INS : (misalign ? STAT_ADR : STAT_AOK);
                mem_we    <= acc_wr;
                mem_addr  <= cap_addr;
                mem_wdata <= cap_wdata;
            end
            if (rd_done)
                valM_o <= mem_rdata;
            if (timed_out) begin
                stat_o <= STAT_ADR;
                valM_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int DW = 32;
    localparam int TMO = 4;
    localparam int NEVER = 99;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    icode_i = '0, ifun_i = '0, dstE_i = '0, dstM_i = '0;
    logic [DW-1:0] valE_i = '0, valA_i = '0, valP_i = '0;
    logic          cnd_i = 1'b0;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] valE_o, valM_o;
    logic [7:0]    dstE_o, dstM_o;
    logic [2:0]    stat_o;

    int passed = 0;
    int total  = 0;

    mem_stage #(.DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .ifun_i(ifun_i),
        .valE_i(valE_i), .valA_i(valA_i), .valP_i(valP_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .cnd_i(cnd_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .valE_o(valE_o), .valM_o(valM_o), .dstE_o(dstE_o), .dstM_o(dstM_o), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: what the stage must do with one bundle.
    typedef struct {
        bit          acc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  stat;
        logic [7:0]  dste;
    } exp_t;

    function automatic exp_t model(input logic [7:0] ic, input logic [31:0] ve, input logic [31:0] va,
                                   input logic [31:0] vp, input logic [7:0] de, input bit cnd);
        exp_t e;
        e.acc = 0; e.we = 0; e.addr = ve; e.wdata = va; e.stat = 3'd1;
        e.dste = (ic == 8'h2 && !cnd) ? 8'hF : de;
        if (ic == 8'h5) e.acc = 1;
        else if (ic == 8'h9 || ic == 8'hB) begin e.acc = 1; e.addr = va; end
        else if (ic == 8'h4 || ic == 8'hA) begin e.acc = 1; e.we = 1; end
        else if (ic == 8'h8) begin e.acc = 1; e.we = 1; e.wdata = vp; end
        else if (ic > 8'hB) e.stat = 3'd4;
`ifdef MEM_ALIGN_CHECK_EN
        if (e.acc && (e.addr % 4) != 0) begin e.acc = 0; e.stat = 3'd3; end
`endif
        return e;
    endfunction

    // One full transaction: capture, serve the bus, check the bundle, hold, retire.
    // gd = request cycles before gnt (NEVER = no gnt), rd = cycles from gnt to rvalid.
    task automatic txn(input string nm, input logic [7:0] ic, input logic [31:0] ve, input logic [31:0] va,
                       input logic [31:0] vp, input logic [7:0] de, input logic [7:0] dm, input bit cnd,
                       input int gd, input int rd, input logic [31:0] rdata, input int hold);
        exp_t e;
        int k, reqc, gcyc, exp_lat, exp_req;
        bit seen, tmo;
        logic [31:0] exp_valm;
        e = model(ic, ve, va, vp, de, cnd);
        tmo = e.acc && (gd >= TMO);
        exp_valm = (e.acc && !e.we && !tmo) ? rdata : 32'h0;
        if (!e.acc) begin exp_lat = 1; exp_req = 0; end
        else if (tmo) begin exp_lat = TMO + 1; exp_req = TMO; end
        else if (e.we) begin exp_lat = gd + 2; exp_req = gd + 1; end
        else begin exp_lat = gd + rd + 2; exp_req = gd + 1; end

        @(negedge clk);
        chk({nm, ".in_ready"}, 32'(in_ready), 32'h1);
        in_valid = 1'b1; icode_i = ic; ifun_i = 8'($urandom); valE_i = ve; valA_i = va;
        valP_i = vp; dstE_i = de; dstM_i = dm; cnd_i = cnd;
        @(posedge clk);
        k = 0; reqc = 0; gcyc = -1; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            // Junk on the input side: must be ignored while the stage is busy.
            icode_i = 8'($urandom); valE_i = $urandom; valA_i = $urandom; valP_i = $urandom;
            dstE_i = 8'($urandom); dstM_i = 8'($urandom); cnd_i = 1'($urandom);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (out_valid) seen = 1;
            else begin
                if (mem_req) begin
                    reqc++;
                    chk({nm, ".mem_addr"}, mem_addr, e.addr);
                    chk({nm, ".mem_we"}, 32'(mem_we), 32'(e.we));
                    if (e.we) chk({nm, ".mem_wdata"}, mem_wdata, e.wdata);
                    if (reqc - 1 == gd) begin
                        mem_gnt = 1'b1; gcyc = k;
                        // rvalid together with gnt must be ignored
                        if (!e.we) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
                    end
                end
                if (gcyc > 0 && !e.we && k == gcyc + rd) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!seen) chk({nm, ".out_valid"}, 32'(out_valid), 32'h1);
        else begin
            chk({nm, ".latency"}, 32'(k), 32'(exp_lat));
            chk({nm, ".req_cycles"}, 32'(reqc), 32'(exp_req));
            chk({nm, ".valE_o"}, valE_o, ve);
            chk({nm, ".valM_o"}, valM_o, exp_valm);
            chk({nm, ".dstE_o"}, 32'(dstE_o), 32'(e.dste));
            chk({nm, ".dstM_o"}, 32'(dstM_o), 32'(dm));
            chk({nm, ".stat_o"}, 32'(stat_o), 32'(tmo ? 3'd3 : e.stat));
        end
        for (int i = 0; i < hold; i++) begin
            if (tmo) begin mem_rvalid = 1'b1; mem_rdata = $urandom | 32'h1; end
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk({nm, ".hold_valid"}, 32'(out_valid), 32'h1);
            chk({nm, ".hold_in_ready"}, 32'(in_ready), 32'h0);
            chk({nm, ".hold_req"}, 32'(mem_req), 32'h0);
            chk({nm, ".hold_valM"}, valM_o, exp_valm);
            chk({nm, ".hold_valE"}, valE_o, ve);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk({nm, ".retire_valid"}, 32'(out_valid), 32'h0);
        chk({nm, ".retire_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        logic [7:0] ics [14];
        ics = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8, 8'h9, 8'hA, 8'hB, 8'hC, 8'hF};

        // Reset state
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'h1);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.mem_req", 32'(mem_req), 32'h0);
        chk("rst.mem_we", 32'(mem_we), 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.valE_o", valE_o, 32'h0);
        chk("rst.valM_o", valM_o, 32'h0);
        chk("rst.dstE_o", 32'(dstE_o), 32'hF);
        chk("rst.dstM_o", 32'(dstM_o), 32'hF);
        chk("rst.stat_o", 32'(stat_o), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        txn("opl",    8'h6, 32'h15,  32'h7,    32'h0,   8'h2, 8'hF, 1'b1, 0, 1, 32'h0, 0);
        txn("rmmovl", 8'h4, 32'h100, 32'hDEAD, 32'h0,   8'hF, 8'hF, 1'b1, 3, 1, 32'h0, 1);
        txn("popl",   8'hB, 32'h200, 32'h1FC,  32'h0,   8'h4, 8'h3, 1'b1, 0, 2, 32'h42, 0);
        txn("mrm_tmo",8'h5, 32'h80,  32'h0,    32'h0,   8'hF, 8'h1, 1'b1, NEVER, 1, 32'h55, 5);
        txn("pushl_u",8'hA, 32'h102, 32'h77,   32'h0,   8'h4, 8'hF, 1'b1, 0, 1, 32'h0, 0);
        txn("cmov_n", 8'h2, 32'h9,   32'h9,    32'h0,   8'h5, 8'hF, 1'b0, 0, 1, 32'h0, 0);
        txn("cmov_y", 8'h2, 32'h9,   32'h9,    32'h0,   8'h5, 8'hF, 1'b1, 0, 1, 32'h0, 0);
        txn("ins",    8'hC, 32'h40,  32'h0,    32'h0,   8'h1, 8'h2, 1'b1, 0, 1, 32'h0, 2);
        txn("call",   8'h8, 32'h1F8, 32'h0,    32'h123, 8'h4, 8'hF, 1'b1, 0, 1, 32'h0, 0);
        txn("ret",    8'h9, 32'h204, 32'h200,  32'h0,   8'h4, 8'hF, 1'b1, 1, 1, 32'h456, 0);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            int gd;
            logic [31:0] ve, va;
            gd = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 2));
            ve = $urandom; va = $urandom;
            if ($urandom_range(0, 3) != 0) begin ve[1:0] = 2'b00; va[1:0] = 2'b00; end
            txn($sformatf("rnd%0d", t), ics[$urandom_range(0, 13)], ve, va, $urandom,
                8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom),
                gd, int'($urandom_range(1, 2)), $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while a request is outstanding
        @(negedge clk);
        in_valid = 1'b1; icode_i = 8'h5; valE_i = 32'h300; dstE_i = 8'h1; dstM_i = 8'h2;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid.req_before", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid.req_dropped", 32'(mem_req), 32'h0);
        chk("mid.out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid.in_ready", 32'(in_ready), 32'h1);
        chk("mid.stat_o", 32'(stat_o), 32'h1);
        chk("mid.dstE_o", 32'(dstE_o), 32'hF);
        txn("post_rst", 8'h5, 32'h300, 32'h0, 32'h0, 8'h1, 8'h2, 1'b1, 0, 1, 32'hCAFE, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
